// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: instruction width, reset PC,
// NOP encoding and the output-queue occupancy states.
package fetch_unit_pkg;

  localparam int unsigned INSTR_WIDTH      = 32;
  localparam int unsigned RESET_PC_DEFAULT = 0;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  // Occupancy of the out register / skid pair.
  localparam logic [1:0] Q_EMPTY    = 2'd0;
  localparam logic [1:0] Q_OUT      = 2'd1;
  localparam logic [1:0] Q_OUT_SKID = 2'd2;

  function automatic logic [1:0] q_state_of(input logic out_valid, input logic skid_valid);
    if (skid_valid)     return Q_OUT_SKID;
    else if (out_valid) return Q_OUT;
    else                return Q_EMPTY;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Out register plus one-entry skid: absorbs the word still in flight when
// decode stalls, so fetch can stall without losing or reordering words.
module fetch_skid_buffer
  import fetch_unit_pkg::*;
#(
  parameter int OPD_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [OPD_WIDTH-1:0]   in_pc,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [OPD_WIDTH-1:0]   out_pc,
  output logic                   skid_valid
);

  logic [INSTR_WIDTH-1:0] skid_instr_q;
  logic [OPD_WIDTH-1:0]   skid_pc_q;

  logic                   out_valid_n;
  logic [INSTR_WIDTH-1:0] out_instr_n;
  logic [OPD_WIDTH-1:0]   out_pc_n;
  logic                   skid_valid_n;
  logic [INSTR_WIDTH-1:0] skid_instr_n;
  logic [OPD_WIDTH-1:0]   skid_pc_n;
  logic                   transfer;

  assign transfer = out_valid && out_ready;

  always_comb begin
    out_valid_n  = out_valid;
    out_instr_n  = out_instr;
    out_pc_n     = out_pc;
    skid_valid_n = skid_valid;
    skid_instr_n = skid_instr_q;
    skid_pc_n    = skid_pc_q;

    case (q_state_of(out_valid, skid_valid))
      Q_EMPTY: begin
        if (in_valid) begin
          out_valid_n = 1'b1;
          out_instr_n = in_instr;
          out_pc_n    = in_pc;
        end
      end
      Q_OUT: begin
        if (transfer) begin
          out_valid_n = in_valid;
          if (in_valid) begin
            out_instr_n = in_instr;
            out_pc_n    = in_pc;
          end
        end else if (in_valid) begin
          skid_valid_n = 1'b1;
          skid_instr_n = in_instr;
          skid_pc_n    = in_pc;
        end
      end
      Q_OUT_SKID: begin
        // Fetch never issues while the skid is full, so nothing can arrive
        // here unless decode is draining the out register this cycle.
        if (transfer) begin
          out_instr_n  = skid_instr_q;
          out_pc_n     = skid_pc_q;
          skid_valid_n = in_valid;
          if (in_valid) begin
            skid_instr_n = in_instr;
            skid_pc_n    = in_pc;
          end
        end
      end
      default: ;
    endcase

    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
      out_instr_n  = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      skid_valid   <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid    <= out_valid_n;
      out_instr    <= out_instr_n;
      out_pc       <= out_pc_n;
      skid_valid   <= skid_valid_n;
      skid_instr_q <= skid_instr_n;
      skid_pc_q    <= skid_pc_n;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC with redirect, one-cycle program memory,
// and a skid-buffered valid/ready interface towards decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          PC_WIDTH  = 8,
  parameter int          OPD_WIDTH = 32,
  parameter int unsigned RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  input  logic                   redirect_valid,
  input  logic [OPD_WIDTH-1:0]   redirect_pc,
  input  logic                   id_ready,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [OPD_WIDTH-1:0]   if_pc,
  output logic                   fetch_err
);

  localparam logic [OPD_WIDTH-1:0] RESET_PC_V = OPD_WIDTH'(RESET_PC);

  logic [OPD_WIDTH-1:0] pc_q;
  logic [OPD_WIDTH-1:0] inflight_pc_q;
  logic                 inflight_valid_q;
  logic                 fetch_err_q;
  logic                 skid_valid;
  logic                 issue;

  // Stop issuing once the word in flight has nowhere to go but the skid.
  assign issue = !redirect_valid && !skid_valid
              && !(if_valid && !id_ready && inflight_valid_q);

  assign mem_addr  = pc_q[PC_WIDTH-1:0];
  assign fetch_err = fetch_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q             <= RESET_PC_V;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      fetch_err_q      <= 1'b0;
    end else begin
      fetch_err_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        pc_q             <= {redirect_pc[OPD_WIDTH-1:2], 2'b00};
        inflight_valid_q <= 1'b0;
      end else if (issue) begin
        pc_q             <= pc_q + OPD_WIDTH'(4);
        inflight_valid_q <= 1'b1;
        inflight_pc_q    <= pc_q;
      end else begin
        inflight_valid_q <= 1'b0;
      end
    end
  end

  // A redirect flushes the queue; the word returning this cycle is dropped.
  fetch_skid_buffer #(
    .OPD_WIDTH (OPD_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .in_valid   (inflight_valid_q),
    .in_instr   (mem_data),
    .in_pc      (inflight_pc_q),
    .out_ready  (id_ready),
    .out_valid  (if_valid),
    .out_instr  (if_instr),
    .out_pc     (if_pc),
    .skid_valid (skid_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus a randomized run against a stream-level model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          PCW = 8;
  localparam int          OPW = 32;
  localparam logic [31:0] RPC = 32'h0;

  logic            clk;
  logic            rst;
  logic [PCW-1:0]  mem_addr;
  logic [31:0]     mem_data;
  logic            redirect_valid;
  logic [OPW-1:0]  redirect_pc;
  logic            id_ready;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [OPW-1:0]  if_pc;
  logic            fetch_err;

  int checks = 0;
  int fails  = 0;

  fetch_unit #(
    .PC_WIDTH  (PCW),
    .OPD_WIDTH (OPW),
    .RESET_PC  (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory contents as a function of the byte address.
  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {8'hA5, ~a, 8'h3C, a};
  endfunction

  always @(posedge clk) mem_data <= word_at(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream-level model: the head of the queue must always be the next
  // expected program-order address; redirects restart the stream.
  logic [31:0] exp_pc;
  int          edges_since;
  int          ready_run;
  logic        err_exp;

  initial begin
    exp_pc      = RPC;
    edges_since = 0;
    ready_run   = 0;
    err_exp     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("m_rst_valid", 32'(if_valid), 32'd0);
        chk("m_rst_err", 32'(fetch_err), 32'd0);
        chk("m_rst_pc", if_pc, 32'd0);
        chk("m_rst_instr", if_instr, 32'd0);
        chk("m_rst_addr", 32'(mem_addr), RPC & 32'hFF);
        exp_pc      = RPC;
        edges_since = 0;
        ready_run   = 0;
        err_exp     = 1'b0;
      end else begin
        if (edges_since < 1000) edges_since++;
        ready_run = id_ready ? ((ready_run < 1000) ? ready_run + 1 : ready_run) : 0;
        chk("m_fetch_err", 32'(fetch_err), 32'(err_exp));
        if (edges_since <= 2) chk("m_bubble", 32'(if_valid), 32'd0);
        if (edges_since == 3) chk("m_first_valid", 32'(if_valid), 32'd1);
        if (ready_run >= 4 && edges_since >= 3) chk("m_throughput", 32'(if_valid), 32'd1);
        if (if_valid) begin
          chk("m_pc", if_pc, exp_pc);
          chk("m_instr", if_instr, word_at(exp_pc[7:0]));
        end
        err_exp = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (redirect_valid) begin
          exp_pc      = {redirect_pc[31:2], 2'b00};
          edges_since = 0;
        end else if (if_valid && id_ready) begin
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  int rst_hold;

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    repeat (3) tick();
    #1;
    chk("d_rst_valid", 32'(if_valid), 32'd0);
    chk("d_rst_addr", 32'(mem_addr), 32'd0);

    // Release and stream with decode always ready.
    tick(); rst = 1'b1; #1;
    chk("d_rel_valid", 32'(if_valid), 32'd0);
    chk("d_rel_addr", 32'(mem_addr), 32'h00);
    tick(); #1;
    chk("d_rel1_valid", 32'(if_valid), 32'd0);
    chk("d_rel1_addr", 32'(mem_addr), 32'h04);
    tick(); #1;
    chk("d_first_valid", 32'(if_valid), 32'd1);
    chk("d_first_pc", if_pc, 32'h0);
    chk("d_first_instr", if_instr, word_at(8'h00));
    tick(); #1;
    chk("d_pc4", if_pc, 32'h4);

    // Three-cycle decode stall with if_pc at 8.
    tick(); id_ready = 1'b0; #1;
    chk("d_stall_pc0", if_pc, 32'h8);
    tick(); #1;
    chk("d_stall_pc1", if_pc, 32'h8);
    chk("d_stall_addr1", 32'(mem_addr), 32'h10);
    tick(); #1;
    chk("d_stall_pc2", if_pc, 32'h8);
    chk("d_stall_addr2", 32'(mem_addr), 32'h10);
    tick(); id_ready = 1'b1; #1;
    chk("d_resume_pc8", if_pc, 32'h8);
    tick(); #1;
    chk("d_resume_pc12", if_pc, 32'hC);
    tick(); tick(); #1;
    chk("d_resume_pc16", if_pc, 32'h10);

    // Fill the skid, then reset asynchronously mid-cycle.
    tick(); id_ready = 1'b0;
    tick(); tick(); #1;
    chk("d_skid_pc", if_pc, 32'h14);
    #1 rst = 1'b0;
    #1;
    chk("d_async_valid", 32'(if_valid), 32'd0);
    chk("d_async_addr", 32'(mem_addr), 32'h0);
    tick(); tick(); rst = 1'b1; id_ready = 1'b1;
    tick(); tick(); #1;
    chk("d_rerel_pc", if_pc, RPC);
    tick();
    tick(); id_ready = 1'b0;

    // Redirect to 0x40 while 0x8 is stalled with 0xC in the skid.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    chk("d_redir_stalled_pc", if_pc, 32'h8);
    tick(); redirect_valid = 1'b0; id_ready = 1'b1; #1;
    chk("d_redir_b1", 32'(if_valid), 32'd0);
    chk("d_redir_err", 32'(fetch_err), 32'd0);
    tick(); #1;
    chk("d_redir_b2", 32'(if_valid), 32'd0);
    tick(); #1;
    chk("d_redir_valid", 32'(if_valid), 32'd1);
    chk("d_redir_pc", if_pc, 32'h40);

    // Misaligned redirect: one-cycle error, fetch from the aligned target.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick(); redirect_valid = 1'b0; #1;
    chk("d_err_pulse", 32'(fetch_err), 32'd1);
    tick(); #1;
    chk("d_err_clear", 32'(fetch_err), 32'd0);
    tick(); #1;
    chk("d_err_pc", if_pc, 32'h40);

    // Memory address wrap at 2^PC_WIDTH.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hF8;
    tick(); redirect_valid = 1'b0; #1;
    chk("d_wrap_addr_f8", 32'(mem_addr), 32'hF8);
    tick(); #1;
    chk("d_wrap_addr_fc", 32'(mem_addr), 32'hFC);
    tick(); #1;
    chk("d_wrap_addr_00", 32'(mem_addr), 32'h00);
    chk("d_wrap_pc_f8", if_pc, 32'hF8);
    tick(); #1;
    chk("d_wrap_pc_fc", if_pc, 32'hFC);
    tick(); #1;
    chk("d_wrap_pc_100", if_pc, 32'h100);
    chk("d_wrap_instr", if_instr, word_at(8'h00));

    // Randomized traffic: stalls, redirects and occasional resets.
    rst_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        rst      = 1'b0;
        rst_hold = $urandom_range(1, 3);
      end
      id_ready       = ((i / 200) % 2 == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
    end
    tick();
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 8, SHALL set the program-memory byte-address width.
REQ-002 Parameter OPD_WIDTH, default 32, SHALL set the PC and operand width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the first fetch address after reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 mem_addr  output  PC_WIDTH  SHALL be the byte address presented to program memory; it equals pc_q[PC_WIDTH-1:0].
REQ-007 mem_data  input  32  SHALL be the instruction word returned by program memory, valid one cycle after mem_addr.
REQ-008 redirect_valid  input  1  SHALL request a branch or jump redirect.
REQ-009 redirect_pc  input  OPD_WIDTH  SHALL be the redirect target.
REQ-010 id_ready  input  1  SHALL indicate that decode accepts if_instr this cycle.
REQ-011 if_valid  output  1  SHALL indicate that if_instr and if_pc hold a valid fetched instruction.
REQ-012 if_instr  output  32  SHALL carry the fetched instruction word.
REQ-013 if_pc  output  OPD_WIDTH  SHALL carry the byte address of if_instr.
REQ-014 fetch_err  output  1  SHALL pulse for one cycle on a misaligned redirect.

Function
REQ-015 Internal state SHALL comprise: pc_q; inflight (valid and pc of the address issued last cycle); out register (if_valid/if_instr/if_pc); a one-entry skid (skid_valid/instr/pc).
REQ-016 Queue states SHALL be EMPTY (out invalid), OUT (out valid, skid empty) and OUT_SKID (both valid); skid_valid SHALL imply if_valid.
REQ-017 An issue SHALL occur in a cycle iff no redirect is present AND skid_valid=0 AND NOT (if_valid AND !id_ready AND inflight_valid).
REQ-018 On issue: pc_q <= pc_q+4 (modulo 2^OPD_WIDTH); inflight_valid <= 1; inflight_pc <= pc_q. Otherwise inflight_valid <= 0 and pc_q holds.
REQ-019 mem_addr SHALL wrap naturally modulo 2^PC_WIDTH (e.g. pc_q=0x100 -> mem_addr=0x00 at PC_WIDTH 8).
REQ-020 Handshake: a transfer occurs when if_valid AND id_ready; while if_valid=1 and id_ready=0, if_instr and if_pc SHALL hold stable.
REQ-021 A returning word (inflight_valid=1) SHALL load the out register if the out register is empty or transferring this cycle with skid empty; otherwise it SHALL load the skid.
REQ-022 On a transfer with skid_valid=1, the out register SHALL load from the skid, and the skid SHALL take any returning word in the same cycle.
REQ-023 Instructions SHALL leave the unit in program order, with none dropped or duplicated.
REQ-024 Throughput with id_ready held at 1 SHALL be one instruction per cycle.
REQ-025 Latency: if_valid SHALL first assert two cycles after the issue of its address.
REQ-026 Redirect SHALL take priority over stall and issue; at the edge sampling redirect_valid=1: pc_q <= {redirect_pc[OPD_WIDTH-1:2],2'b00}; inflight_valid, if_valid and skid_valid <= 0.
REQ-027 The in-flight response at a redirect edge SHALL be discarded and SHALL never appear on if_instr.
REQ-028 The first if_valid after a redirect SHALL occur exactly two cycles after the redirect edge, with if_pc equal to the aligned target.
REQ-029 redirect_pc[1:0] != 0 SHALL pulse fetch_err for exactly one cycle, registered at the redirect edge; the redirect still takes effect.
REQ-030 A redirect in the same cycle as a transfer SHALL complete the transfer to decode before the flush.

Reset
REQ-031 While rst=0: pc_q=RESET_PC; inflight_valid=0; if_valid=0; if_instr=0; if_pc=0; skid_valid=0; fetch_err=0.
REQ-032 rst assertion mid-stream SHALL clear all state immediately (asynchronously); the first issue SHALL be at RESET_PC on the first edge after release.

Structure
REQ-033 RESET_PC default, the instruction width (32) and the NOP encoding 32'h00000013 SHALL live in the shared CPU definitions header.
REQ-034 The skid/out register pair SHALL be one sub-module, fetch_skid_buffer, parameterised on OPD_WIDTH.

Verification
REQ-035 Reset release, id_ready=1, memory word = address -> if_pc 0,4,8,12 on consecutive cycles; first if_valid two cycles after release.
REQ-036 id_ready=0 for 3 cycles while streaming -> if_pc frozen (e.g. 8); no issue after the skid fills; resumes 12,16 with no loss.
REQ-037 Redirect to 0x40 while if_pc=0x8 is stalled -> stale words 0xC/0x10 never output; if_pc=0x40 exactly two cycles after the redirect edge.
REQ-038 Redirect to 0x42 -> fetch_err high for one cycle; fetch proceeds from 0x40.
REQ-039 With PC_WIDTH=8, stream across pc_q 0xFC->0x100 -> mem_addr 0xFC then 0x00; if_pc=0x100.
REQ-040 rst=0 asserted while in state OUT_SKID -> if_valid=0 immediately; after release, first if_pc=RESET_PC.
